// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: shadow pipeline of in-flight writers producing
// registered EX forwarding selects and a combinational load-use stall.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   id_valid        ID holds a real instruction
//   id_rs_vec       ID source indices, operand i at [i*REG_AW +: REG_AW]
//   id_rd           ID destination register
//   id_regwrite     ID instruction writes a register
//   id_memread      ID instruction is a load
//   flush           squash the instruction advancing into EX
//   fwd_sel_vec     per-operand EX select (0 = regfile, k = stage k)
//   stall           hold PC and IF/ID, bubble into EX
//   stat_stall_cnt  cycles with stall high (FWD_HAZARD_STATS_EN only)
//   stat_fwd_cnt    EX entries with any forward (FWD_HAZARD_STATS_EN only)
//
// Optional feature macro: FWD_HAZARD_STATS_EN adds saturating counters.
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_vec,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      flush,
`ifdef FWD_HAZARD_STATS_EN
  output logic [15:0]               stat_stall_cnt,
  output logic [15:0]               stat_fwd_cnt,
`endif
  output logic [NUM_SRC*SELW-1:0]   fwd_sel_vec,
  output logic                      stall
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              load;
  } shadow_t;

  // Only stages 0..FWD_DEPTH-1 are ever compared; the oldest stage
  // has already committed (write-first regfile) by the time a new
  // instruction reaches EX, so it is not kept.
  shadow_t sh_q [FWD_DEPTH];

  logic [REG_AW-1:0] rs_w    [NUM_SRC];
  logic [SELW-1:0]   best    [NUM_SRC];
  logic              best_ld [NUM_SRC];
  logic              hazard;
  logic              issue;
  logic              any_fwd;
  logic [NUM_SRC*SELW-1:0] sel_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_rs
    assign rs_w[g] = id_rs_vec[g*REG_AW +: REG_AW];
  end

  function automatic logic hit(shadow_t e, logic [REG_AW-1:0] rs);
    return e.valid && e.regwrite &&
           (e.rd != '0) && (e.rd == rs);
  endfunction

  // Scan oldest to youngest so the youngest match is the last write.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      best[i]    = '0;
      best_ld[i] = 1'b0;
      for (int s = FWD_DEPTH - 1; s >= 0; s--) begin
        if (hit(sh_q[s], rs_w[i])) begin
          best[i]    = SELW'(s + 1);
          best_ld[i] = sh_q[s].load;
        end
      end
    end
  end

  // A younger load shadows any older ALU writer of the same reg.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (best_ld[i] && (32'(best[i]) < LOAD_STAGE))
        hazard = 1'b1;
    end
  end

  assign stall = id_valid && hazard;
  assign issue = id_valid && !stall && !flush;

  always_comb begin
    any_fwd = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (best[i] != '0)
        any_fwd = 1'b1;
    end
    any_fwd = any_fwd && issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < FWD_DEPTH; s++)
        sh_q[s] <= '0;
    end else begin
      if (issue) begin
        sh_q[0].valid    <= 1'b1;
        sh_q[0].rd       <= id_rd;
        sh_q[0].regwrite <= id_regwrite;
        sh_q[0].load     <= id_memread;
      end else begin
        sh_q[0] <= '0;
      end
      for (int s = 1; s < FWD_DEPTH; s++)
        sh_q[s] <= sh_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++)
        sel_q[i*SELW +: SELW] <= issue ? best[i] : '0;
    end
  end

  assign fwd_sel_vec = sel_q;

`ifdef FWD_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (any_fwd && (fwd_cnt_q != 16'hFFFF))
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_fwd_cnt   = fwd_cnt_q;
`else
  logic unused_fwd;
  assign unused_fwd = any_fwd;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding selects and
// load-use stalls on a default and a deep-load configuration.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [9:0] id_rs_vec;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;
  logic [3:0] fwd_sel_vec;
  logic       stall;
  logic [3:0] fwd_sel_vec3;
  logic       stall3;
`ifdef FWD_HAZARD_STATS_EN
  logic [15:0] stat_stall_cnt;
  logic [15:0] stat_fwd_cnt;
  logic [15:0] stat_stall_cnt3;
  logic [15:0] stat_fwd_cnt3;
`endif

  int n_cmp;
  int n_bad;

  fwd_hazard_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs_vec   (id_rs_vec),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
`ifdef FWD_HAZARD_STATS_EN
    .stat_stall_cnt (stat_stall_cnt),
    .stat_fwd_cnt   (stat_fwd_cnt),
`endif
    .fwd_sel_vec (fwd_sel_vec),
    .stall       (stall)
  );

  fwd_hazard_unit #(
    .FWD_DEPTH  (3),
    .LOAD_STAGE (3)
  ) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs_vec   (id_rs_vec),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
`ifdef FWD_HAZARD_STATS_EN
    .stat_stall_cnt (stat_stall_cnt3),
    .stat_fwd_cnt   (stat_fwd_cnt3),
`endif
    .fwd_sel_vec (fwd_sel_vec3),
    .stall       (stall3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(logic v, logic [4:0] r0, logic [4:0] r1,
                    logic [4:0] rd, logic rw, logic ld);
    id_valid    = v;
    id_rs_vec   = {r1, r0};
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = ld;
  endtask

  task automatic clear();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    flush = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #12;
    chk("reset_sel", 32'(fwd_sel_vec), 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    rst_n = 1'b1;
    tick();

    // writer r3 then reader {r3,r4}
    id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    tick();
    chk("fwd_exmem", 32'(fwd_sel_vec), 32'h1);
    clear();

    // writer r3, gap, reader {r5,r3}
    id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd5, 5'd3, 5'd0, 1'b0, 1'b0);
    tick();
    chk("fwd_memwb", 32'(fwd_sel_vec), 32'h8);
    clear();

    // writer r3, two gaps, reader: already committed
    id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0);
    tick();
    tick();
    id(1'b1, 5'd5, 5'd3, 5'd0, 1'b0, 1'b0);
    tick();
    chk("fwd_too_old", 32'(fwd_sel_vec), 32'h0);
    clear();

    // two writers of r7: youngest wins
    id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    tick();
    id(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("fwd_youngest", 32'(fwd_sel_vec), 32'h1);
    clear();

    // load r8 then immediate reader
    id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1);
    tick();
    id(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("lu_stall_on", 32'(stall), 32'h1);
    tick();
    chk("lu_bubble_sel", 32'(fwd_sel_vec), 32'h0);
    chk("lu_stall_off", 32'(stall), 32'h0);
    tick();
    chk("lu_fwd_sel", 32'(fwd_sel_vec), 32'h2);
    chk("lu_no_restall", 32'(stall), 32'h0);
`ifdef FWD_HAZARD_STATS_EN
    chk("stat_stall", 32'(stat_stall_cnt), 32'h1);
    chk("stat_fwd", 32'(stat_fwd_cnt), 32'h4);
`endif
    clear();

    // r0 is never forwarded nor stalled on
    id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("r0_no_stall", 32'(stall), 32'h0);
    tick();
    chk("r0_sel", 32'(fwd_sel_vec), 32'h0);
    clear();

    // flushed writer never forwards
    id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("flush_sel", 32'(fwd_sel_vec), 32'h0);
    clear();

    // reset asserted mid-stall
    id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1);
    tick();
    id(1'b1, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0);
    #1;
    chk("rst_pre_stall", 32'(stall), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_sel", 32'(fwd_sel_vec), 32'h0);
`ifdef FWD_HAZARD_STATS_EN
    chk("rst_stat", 32'(stat_stall_cnt), 32'h0);
`endif
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    clear();

    // deep config: load r9 then reader -> two stalls then sel 3
    id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    tick();
    id(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("d3_stall1", 32'(stall3), 32'h1);
    tick();
    chk("d3_stall2", 32'(stall3), 32'h1);
    chk("d3_bubble1", 32'(fwd_sel_vec3), 32'h0);
    tick();
    chk("d3_stall_off", 32'(stall3), 32'h0);
    chk("d3_bubble2", 32'(fwd_sel_vec3), 32'h0);
    tick();
    chk("d3_fwd_sel", 32'(fwd_sel_vec3), 32'h3);
    clear();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
